message_reg_host: RTL and testbench
===================================

// Module: message_reg_host
// PURPOSE
//   Host-side word entry register for the wireless hangman game. Collects the secret
//   word one ASCII letter at a time from the keypad decoder (setLetter + key_ready
//   strobe) into a 5-character register (temp_word) for the host display/transmitter.
//   Signals word completion (rec_ready, toggle_state) and a host-requested game end.
// PARAMETERS
//   WORD_LEN  5      letters per word; temp_word width = 8*WORD_LEN
//   END_KEY   8'h2A  ASCII code ('*') that requests game end
// PORTS
//   clk           in   1   system clock, all state updates on rising edge
//   nRst          in   1   reset, asynchronous, active-high (1 = reset asserted)
//   key_ready     in   1   keypad strobe; setLetter valid while high
//   setLetter     in   8   ASCII code of pressed key
//   rec_ready     out  1   one-cycle pulse: full word captured
//   toggle_state  out  1   level; inverts on every completed word
//   gameEnd_host  out  1   sticky flag: END_KEY accepted
//   temp_word     out  40  captured letters, oldest in [39:32], newest in [7:0]
// BEHAVIOUR
// - Reset (async, nRst=1): temp_word=0, letter count=0, rec_ready=0, toggle_state=0,
//   gameEnd_host=0, key_ready edge register=0, state=COLLECT. Takes effect immediately,
//   mid-word included; partial word is discarded.
// - key_ready sampled synchronously into key_q; a press = key_ready=1 && key_q=0 at a
//   rising clk. Holding key_ready high for N cycles = exactly one press. Pulses shorter
//   than a clock period are captured only if high at a rising edge.
// - setLetter sampled on the same edge as the press detect.
// - Valid letter: 8'h41..8'h5A ('A'..'Z'). Anything else except END_KEY is ignored
//   (no register, count or flag change).
// - States: COLLECT, FULL, END.
//   COLLECT: valid press -> temp_word <= {temp_word[31:0], setLetter}, count+1.
//     When count reaches 5 on that edge -> FULL; rec_ready=1 for the next cycle
//     only; toggle_state inverts on same edge.
//   FULL: temp_word held. Next valid press starts a new word:
//     temp_word <= {32'h0, setLetter}, count=1, -> COLLECT.
//   Any state: press with setLetter==END_KEY -> END, gameEnd_host=1.
//     temp_word and toggle_state keep their values.
//   END: all presses ignored; gameEnd_host stays 1 until reset.
// - Latency: temp_word reflects a press one cycle after the edge detect (registered).
// - Count is 3 bits, never exceeds 5; no wrap. rec_ready never asserts on a partial
//   word. Simultaneous reset and press: reset wins.
// - All outputs registered; no combinational path from inputs to outputs.
// TESTING
// 1 Reset: nRst=1 two cycles mid-operation -> temp_word=40'h0, rec_ready=0,
//   toggle_state=0, gameEnd_host=0 immediately.
// 2 Hold: key_ready=1 two cycles, setLetter=8'h41 -> temp_word=40'h00_0000_0041,
//   one capture only; key_ready low with setLetter=8'h46 -> no change.
// 3 Full word: presses 'H','E','L','L','O' -> temp_word=40'h48454C4C4F, rec_ready high
//   exactly one cycle, toggle_state 0->1; 6th press 'C' -> temp_word=40'h43.
// 4 Invalid: press 8'h61 or 8'h31 -> temp_word, count, flags unchanged.
// 5 Game end: after 'A','C', press 8'h2A -> gameEnd_host=1, temp_word=40'h4143;
//   further presses ignored until reset.
// 6 Short pulse: key_ready high 0.5 period spanning a rising edge with 'C' -> one capture;
//   not spanning an edge -> no capture.

Source files
------------

// File: rtl/message_reg_host_if.sv
// Keypad-to-host word entry bus: keypad strobe/letter in, captured word and
// completion/game-end flags out.
interface message_reg_host_if;
  logic        key_ready;
  logic [7:0]  setLetter;
  logic        rec_ready;
  logic        toggle_state;
  logic        gameEnd_host;
  logic [39:0] temp_word;

  modport master (
    output key_ready,
    output setLetter,
    input  rec_ready,
    input  toggle_state,
    input  gameEnd_host,
    input  temp_word
  );

  modport slave (
    input  key_ready,
    input  setLetter,
    output rec_ready,
    output toggle_state,
    output gameEnd_host,
    output temp_word
  );
endinterface

// File: rtl/message_reg_host.sv
// Host-side secret-word entry register for the hangman game: collects one ASCII
// letter per keypad press into a WORD_LEN-letter register and flags completion/game end.
module message_reg_host #(
  parameter int          WORD_LEN = 5,
  parameter logic [7:0]  END_KEY  = 8'h2A
) (
  input  logic               clk,
  input  logic               nRst,
  message_reg_host_if.slave  bus
);

  localparam int         W        = 8 * WORD_LEN;
  localparam logic [2:0] FULL_CNT = 3'(WORD_LEN);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_FULL    = 2'd1,
    ST_END     = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           key_q;
  logic [2:0]     count_q, count_d;
  logic [W-1:0]   word_q, word_d;
  logic           rec_ready_q, rec_ready_d;
  logic           toggle_q, toggle_d;
  logic           game_end_q, game_end_d;

  logic           press_s;
  logic           valid_s;
  logic           end_s;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  assign press_s = bus.key_ready & ~key_q;
  assign valid_s = is_letter(bus.setLetter);
  assign end_s   = (bus.setLetter == END_KEY);

  // Next-state and next-output decode for the word collection FSM
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_d      = word_q;
    rec_ready_d = 1'b0;
    toggle_d    = toggle_q;
    game_end_d  = game_end_q;
    case (state_q)
      ST_COLLECT: begin
        if (press_s && end_s) begin
          state_d    = ST_END;
          game_end_d = 1'b1;
        end else if (press_s && valid_s) begin
          word_d  = {word_q[W-9:0], bus.setLetter};
          count_d = count_q + 3'd1;
          if ((count_q + 3'd1) == FULL_CNT) begin
            state_d     = ST_FULL;
            rec_ready_d = 1'b1;
            toggle_d    = ~toggle_q;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_FULL: begin
        // A fresh letter after a complete word starts the next word from scratch
        if (press_s && end_s) begin
          state_d    = ST_END;
          game_end_d = 1'b1;
        end else if (press_s && valid_s) begin
          word_d  = {{(W-8){1'b0}}, bus.setLetter};
          count_d = 3'd1;
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_FULL;
        end
      end
      ST_END: begin
        state_d = ST_END;
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // State, key edge register and output registers
  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      state_q     <= ST_COLLECT;
      key_q       <= 1'b0;
      count_q     <= 3'd0;
      word_q      <= '0;
      rec_ready_q <= 1'b0;
      toggle_q    <= 1'b0;
      game_end_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= bus.key_ready;
      count_q     <= count_d;
      word_q      <= word_d;
      rec_ready_q <= rec_ready_d;
      toggle_q    <= toggle_d;
      game_end_q  <= game_end_d;
    end
  end

  assign bus.temp_word    = word_q;
  assign bus.rec_ready    = rec_ready_q;
  assign bus.toggle_state = toggle_q;
  assign bus.gameEnd_host = game_end_q;

endmodule

// File: tb/tb_message_reg_host.sv
// Directed bench for message_reg_host: reset, hold, full word, invalid keys,
// game end and short key pulses, checked against hand-computed values.
module tb_message_reg_host;

  logic clk;
  logic nRst;
  int   pass_cnt;
  int   total_cnt;

  message_reg_host_if bus ();

  message_reg_host dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic press(input logic [7:0] c);
    @(negedge clk);
    bus.key_ready = 1'b1;
    bus.setLetter = c;
    @(negedge clk);
    bus.key_ready = 1'b0;
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    nRst          = 1'b1;
    bus.key_ready = 1'b0;
    bus.setLetter = 8'h00;

    @(negedge clk);
    check("rst_word", bus.temp_word, 40'h0);
    check("rst_rec", {39'h0, bus.rec_ready}, 40'h0);
    check("rst_tog", {39'h0, bus.toggle_state}, 40'h0);
    check("rst_end", {39'h0, bus.gameEnd_host}, 40'h0);
    nRst = 1'b0;

    // key held high for two edges counts as a single press
    @(negedge clk);
    bus.key_ready = 1'b1;
    bus.setLetter = 8'h41;
    @(negedge clk);
    @(negedge clk);
    bus.key_ready = 1'b0;
    check("hold_once", bus.temp_word, 40'h00_0000_0041);
    bus.setLetter = 8'h46;
    @(negedge clk);
    @(negedge clk);
    check("no_key_no_change", bus.temp_word, 40'h00_0000_0041);

    // mid-word asynchronous reset discards the partial word
    @(negedge clk);
    #2 nRst = 1'b1;
    #1 check("midrst_word", bus.temp_word, 40'h0);
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b0;

    press(8'h48);
    press(8'h45);
    press(8'h4C);
    press(8'h4C);
    check("hell_word", bus.temp_word, 40'h00_4845_4C4C);
    check("hell_no_rec", {39'h0, bus.rec_ready}, 40'h0);
    press(8'h4F);
    check("hello_word", bus.temp_word, 40'h48_454C_4C4F);
    check("hello_rec", {39'h0, bus.rec_ready}, 40'h1);
    check("hello_tog", {39'h0, bus.toggle_state}, 40'h1);
    @(negedge clk);
    check("rec_one_cycle", {39'h0, bus.rec_ready}, 40'h0);

    press(8'h61);
    check("inv_lower_word", bus.temp_word, 40'h48_454C_4C4F);
    check("inv_lower_tog", {39'h0, bus.toggle_state}, 40'h1);
    press(8'h31);
    check("inv_digit_word", bus.temp_word, 40'h48_454C_4C4F);
    check("inv_digit_rec", {39'h0, bus.rec_ready}, 40'h0);

    // half-period pulse straddling a rising edge starts a new word with 'C'
    @(negedge clk);
    #3 bus.key_ready = 1'b1;
    bus.setLetter = 8'h43;
    #5 bus.key_ready = 1'b0;
    @(negedge clk);
    check("short_span", bus.temp_word, 40'h00_0000_0043);
    @(negedge clk);
    #1 bus.key_ready = 1'b1;
    bus.setLetter = 8'h44;
    #3 bus.key_ready = 1'b0;
    @(negedge clk);
    check("short_nospan", bus.temp_word, 40'h00_0000_0043);
    check("short_tog", {39'h0, bus.toggle_state}, 40'h1);

    @(negedge clk);
    #2 nRst = 1'b1;
    #1 check("rst2_word", bus.temp_word, 40'h0);
    check("rst2_tog", {39'h0, bus.toggle_state}, 40'h0);
    @(negedge clk);
    @(negedge clk);
    nRst = 1'b0;

    // invalid key inside a word must not advance the letter count
    press(8'h51);
    press(8'h52);
    press(8'h61);
    press(8'h53);
    press(8'h54);
    check("qrst_word", bus.temp_word, 40'h00_5152_5354);
    check("qrst_no_rec", {39'h0, bus.rec_ready}, 40'h0);
    press(8'h55);
    check("qrstu_word", bus.temp_word, 40'h51_5253_5455);
    check("qrstu_rec", {39'h0, bus.rec_ready}, 40'h1);
    check("qrstu_tog", {39'h0, bus.toggle_state}, 40'h1);

    press(8'h41);
    press(8'h43);
    press(8'h2A);
    check("end_flag", {39'h0, bus.gameEnd_host}, 40'h1);
    check("end_word", bus.temp_word, 40'h00_0000_4143);
    check("end_tog", {39'h0, bus.toggle_state}, 40'h1);
    press(8'h42);
    check("end_ignore_word", bus.temp_word, 40'h00_0000_4143);
    check("end_sticky", {39'h0, bus.gameEnd_host}, 40'h1);

    @(negedge clk);
    #2 nRst = 1'b1;
    #1 check("rst3_end", {39'h0, bus.gameEnd_host}, 40'h0);
    check("rst3_word", bus.temp_word, 40'h0);
    @(negedge clk);
    nRst = 1'b0;
    press(8'h5A);
    check("after_rst_word", bus.temp_word, 40'h00_0000_005A);
    check("after_rst_end", {39'h0, bus.gameEnd_host}, 40'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
